// File: rtl/o_delay_tap_ctrl.sv
// o_delay_tap_ctrl
// Sequencer for one O_DELAY instance: optionally reloads DELAY, then steps the
// tap one DLY_ADJ pulse at a time until DLY_TAP_VALUE equals the requested tap.
// Optional watchdog: define O_DELAY_CTRL_TIMEOUT_EN.
//
// Ports:
//   CLK_IN, RST          clock (O_DELAY CLK_IN domain), async active-high reset
//   REQ_VALID/REQ_READY  request handshake; REQ_LOAD, REQ_TAP request payload
//   BUSY, DONE, ERR      status (DONE one-cycle pulse, ERR sticky until next accept)
//   CUR_TAP              registered copy of DLY_TAP_VALUE
//   DLY_LOAD/DLY_ADJ/DLY_INCDEC  controls to O_DELAY; DLY_TAP_VALUE from O_DELAY
module o_delay_tap_ctrl #(
  parameter int DELAY          = 0,
  parameter int GAP_CYCLES     = 1,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_LOAD,
  input  logic [5:0] REQ_TAP,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [5:0] CUR_TAP,
  output logic       DLY_LOAD,
  output logic       DLY_ADJ,
  output logic       DLY_INCDEC,
  input  logic [5:0] DLY_TAP_VALUE
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_COMPARE,
    S_SETUP, S_PULSE, S_GAP, S_DONE, S_ERROR
  } state_t;

  localparam logic [5:0] DLY6        = 6'(DELAY);
  localparam logic [3:0] GAP_LAST    = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [5:0] r_tgt, r_prev, r_cur;
  logic       r_ld, r_err, r_incdec, r_rdy;
  logic       w_accept, w_timeout;
  logic [5:0] w_tap;

  assign w_tap    = DLY_TAP_VALUE;
  assign w_accept = REQ_VALID && REQ_READY;

`ifdef O_DELAY_CTRL_TIMEOUT_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES * (2 + GAP_CYCLES + SETTLE_CYCLES));
  logic [15:0] r_wd;

  // Watchdog only fires while the request can still complete.
  assign w_timeout = (r_wd >= WD_LIMIT) &&
                     !(r_state inside {S_IDLE, S_DONE, S_ERROR});

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST)                         r_wd <= '0;
    else if (w_accept)               r_wd <= '0;
    else if (BUSY && r_wd != '1)     r_wd <= r_wd + 16'd1;
  end
`else
  logic w_unused;
  assign w_timeout = 1'b0;
  assign w_unused  = 1'(TIMEOUT_CYCLES);
`endif

  // Next state. The stuck-tap check and the target compare of a step are
  // folded into the final settle cycle, so each step costs exactly
  // SETUP + PULSE + GAP_CYCLES + SETTLE_CYCLES cycles.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = REQ_LOAD ? S_LOAD : S_COMPARE;
      S_LOAD:    if (r_cnt == 4'd1) w_next = S_SETTLE;
      S_SETTLE:  if (r_cnt == SETTLE_LAST) begin
                   if (r_ld)                 w_next = S_CHECK;
                   else if (w_tap == r_prev) w_next = S_ERROR;
                   else if (w_tap == r_tgt)  w_next = S_DONE;
                   else                      w_next = S_SETUP;
                 end
      S_CHECK:   w_next = (w_tap != DLY6) ? S_ERROR : S_COMPARE;
      S_COMPARE: w_next = (w_tap == r_tgt) ? S_DONE : S_SETUP;
      S_SETUP:   w_next = S_PULSE;
      S_PULSE:   w_next = S_GAP;
      S_GAP:     if (r_cnt == GAP_LAST) w_next = S_SETTLE;
      S_DONE:    w_next = S_IDLE;
      S_ERROR:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_ERROR;
  end

  always_ff @(posedge CLK_IN or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tgt    <= '0;
      r_prev   <= '0;
      r_cur    <= '0;
      r_ld     <= 1'b0;
      r_err    <= 1'b0;
      r_incdec <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cur   <= DLY_TAP_VALUE;
      r_rdy   <= 1'b1;
      r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
      if (w_accept) begin
        r_tgt <= REQ_TAP;
        r_ld  <= REQ_LOAD;
        r_err <= 1'b0;
      end else if (w_next == S_ERROR) begin
        r_err <= 1'b1;
      end
      if (r_state == S_CHECK) r_ld <= 1'b0;
      // Direction and reference tap are latched when a new step begins.
      if (w_next == S_SETUP && r_state != S_SETUP) begin
        r_incdec <= (r_tgt > w_tap);
        r_prev   <= w_tap;
      end
    end
  end

  assign REQ_READY  = r_rdy && (r_state == S_IDLE);
  assign BUSY       = (r_state != S_IDLE);
  assign DONE       = (r_state == S_DONE);
  assign ERR        = r_err;
  assign CUR_TAP    = r_cur;
  assign DLY_LOAD   = (r_state == S_LOAD);
  assign DLY_ADJ    = (r_state == S_PULSE) && !w_timeout;
  assign DLY_INCDEC = r_incdec;

endmodule
